// File: rtl/adc_capture_pkg.sv
// Shared types and constants for the ADC capture buffer (writer and read controller).
//   cap_state_t  : writer FSM state. IDLE is all-zero and each active state owns one bit.
//   NUM_FIFO_DEF : default number of sample FIFOs.
//   ADDR_W       : width of a FIFO index.
package adc_capture_pkg;

  localparam int unsigned NUM_FIFO_DEF = 6;
  localparam int unsigned ADDR_W       = 3;

  typedef enum logic [2:0] {
    IDLE    = 3'b000,
    ARMED   = 3'b001,
    CAPTURE = 3'b010,
    DONE    = 3'b100
  } cap_state_t;

endpackage

// File: rtl/adc_capture_writer_trig_edge_detect.sv
// Trigger conditioner: 2-flop synchroniser followed by a registered rising-edge pulse.
// The pulse is high for one cycle, 3 clocks after the input level rises.
//   i_clk   : clock
//   i_rst   : synchronous active-high reset
//   i_d     : asynchronous trigger level
//   o_pulse : one-cycle rising-edge pulse
module trig_edge_detect (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_d,
  output logic o_pulse
);

  logic r_sync1;
  logic r_sync2;
  logic r_sync3;
  logic r_pulse;

  // r_sync1/r_sync2 resolve metastability; r_sync3 is the previous level for edge detection
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_sync3 <= 1'b0;
      r_pulse <= 1'b0;
    end else begin
      r_sync1 <= i_d;
      r_sync2 <= r_sync1;
      r_sync3 <= r_sync2;
      r_pulse <= r_sync2 & ~r_sync3;
    end
  end

  assign o_pulse = r_pulse;

endmodule

// File: rtl/adc_capture_writer.sv
// ADC capture writer: arms on a software pulse, waits for a trigger edge, then writes
// CAPTURE_LEN samples round-robin into NUM_FIFO FIFOs. o_capture_done holds until all
// FIFOs are empty. All outputs are registered.
// Optional build macro ADC_CAPTURE_TEST_PATTERN_EN: wr_data carries a ramp starting at 0
// for each capture instead of the ADC sample.
//   i_clk, i_rst     : clock, synchronous active-high reset
//   i_arm            : single-cycle arm request
//   i_trig           : asynchronous trigger level
//   i_adc_data/valid : ADC sample stream
//   i_fifo_full      : per-FIFO full flags
//   i_fifo_empty     : per-FIFO empty flags
//   o_wr_en          : one-hot FIFO write strobe
//   o_wr_data        : sample written
//   o_capture_done   : capture complete, FIFOs hold data
//   o_busy           : high in ARMED, CAPTURE and DONE
//   o_overflow       : sticky, a sample was dropped on a full FIFO
module adc_capture_writer
  import adc_capture_pkg::*;
#(
  parameter int unsigned NUM_FIFO    = NUM_FIFO_DEF,
  parameter int unsigned DATA_W      = 16,
  parameter int unsigned CAPTURE_LEN = 6144
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_arm,
  input  logic                i_trig,
  input  logic [DATA_W-1:0]   i_adc_data,
  input  logic                i_adc_valid,
  input  logic [NUM_FIFO-1:0] i_fifo_full,
  input  logic [NUM_FIFO-1:0] i_fifo_empty,
  output logic [NUM_FIFO-1:0] o_wr_en,
  output logic [DATA_W-1:0]   o_wr_data,
  output logic                o_capture_done,
  output logic                o_busy,
  output logic                o_overflow
);

  localparam int unsigned PTR_W = (NUM_FIFO > 1) ? $clog2(NUM_FIFO) : 1;
  localparam int unsigned CNT_W = 16;

  cap_state_t          r_state;
  logic [NUM_FIFO-1:0] r_wr_en;
  logic [DATA_W-1:0]   r_wr_data;
  logic [PTR_W-1:0]    r_ptr;
  logic [CNT_W-1:0]    r_cnt;
  logic                r_overflow;
  logic                r_busy;
  logic                r_done;

  cap_state_t          w_state_nxt;
  logic [NUM_FIFO-1:0] w_wr_en_nxt;
  logic [DATA_W-1:0]   w_wr_data_nxt;
  logic [PTR_W-1:0]    w_ptr_nxt;
  logic [CNT_W-1:0]    w_cnt_nxt;
  logic [CNT_W-1:0]    w_cnt_inc;
  logic                w_overflow_nxt;
  logic                w_all_empty;
  logic                w_trig_re;

`ifdef ADC_CAPTURE_TEST_PATTERN_EN
  logic [DATA_W-1:0]   r_ramp;
  logic [DATA_W-1:0]   w_ramp_nxt;
`endif

  trig_edge_detect u_trig (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_d     (i_trig),
    .o_pulse (w_trig_re)
  );

  assign w_all_empty = &i_fifo_empty;
  assign w_cnt_inc   = r_cnt + CNT_W'(1);

  // State and output registers
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= IDLE;
      r_wr_en    <= '0;
      r_wr_data  <= '0;
      r_ptr      <= '0;
      r_cnt      <= '0;
      r_overflow <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
`ifdef ADC_CAPTURE_TEST_PATTERN_EN
      r_ramp     <= '0;
`endif
    end else begin
      r_state    <= w_state_nxt;
      r_wr_en    <= w_wr_en_nxt;
      r_wr_data  <= w_wr_data_nxt;
      r_ptr      <= w_ptr_nxt;
      r_cnt      <= w_cnt_nxt;
      r_overflow <= w_overflow_nxt;
      r_busy     <= (w_state_nxt != IDLE);
      r_done     <= (w_state_nxt == DONE);
`ifdef ADC_CAPTURE_TEST_PATTERN_EN
      r_ramp     <= w_ramp_nxt;
`endif
    end
  end

  // Next state, write strobe and bookkeeping
  always_comb begin
    w_state_nxt    = r_state;
    w_wr_en_nxt    = '0;
    w_wr_data_nxt  = r_wr_data;
    w_ptr_nxt      = r_ptr;
    w_cnt_nxt      = r_cnt;
    w_overflow_nxt = r_overflow;
`ifdef ADC_CAPTURE_TEST_PATTERN_EN
    w_ramp_nxt     = r_ramp;
`endif
    case (r_state)
      IDLE: begin
        // Arm only when the previous capture has been fully drained
        if (i_arm && w_all_empty) begin
          w_state_nxt    = ARMED;
          w_overflow_nxt = 1'b0;
        end
      end
      ARMED: begin
        // The sample coincident with the trigger edge is not captured
        if (w_trig_re) begin
          w_state_nxt = CAPTURE;
          w_ptr_nxt   = '0;
          w_cnt_nxt   = '0;
`ifdef ADC_CAPTURE_TEST_PATTERN_EN
          w_ramp_nxt  = '0;
`endif
        end
      end
      CAPTURE: begin
        if (i_adc_valid) begin
          if (!i_fifo_full[r_ptr]) begin
            w_wr_en_nxt = NUM_FIFO'(1) << r_ptr;
`ifdef ADC_CAPTURE_TEST_PATTERN_EN
            w_wr_data_nxt = r_ramp;
            w_ramp_nxt    = r_ramp + DATA_W'(1);
`else
            w_wr_data_nxt = i_adc_data;
`endif
            w_ptr_nxt = (r_ptr == PTR_W'(NUM_FIFO - 1)) ? '0 : r_ptr + PTR_W'(1);
            w_cnt_nxt = w_cnt_inc;
            if (w_cnt_inc == CNT_W'(CAPTURE_LEN)) begin
              w_state_nxt = DONE;
            end
          end else begin
            // Drop; pointer and counter hold so the next sample retries this FIFO
            w_overflow_nxt = 1'b1;
          end
        end
      end
      DONE: begin
        if (w_all_empty) begin
          w_state_nxt = IDLE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  assign o_wr_en        = r_wr_en;
  assign o_wr_data      = r_wr_data;
  assign o_capture_done = r_done;
  assign o_busy         = r_busy;
  assign o_overflow     = r_overflow;

endmodule

// File: tb/tb_adc_capture_writer.sv
// Bench for adc_capture_writer: a vector table for reset/arm/idle behaviour, hand-written
// capture, overflow and reset-abort sequences, then randomized traffic. Every cycle is also
// checked against a transaction-level reference model.
module tb_adc_capture_writer;

  localparam int NF  = 6;
  localparam int DW  = 16;
  localparam int LEN = 12;

  logic          clk;
  logic          rst;
  logic          arm;
  logic          trig;
  logic [DW-1:0] adc_data;
  logic          adc_valid;
  logic [NF-1:0] fifo_full;
  logic [NF-1:0] fifo_empty;
  logic [NF-1:0] wr_en;
  logic [DW-1:0] wr_data;
  logic          capture_done;
  logic          busy;
  logic          overflow;

  adc_capture_writer #(
    .NUM_FIFO    (NF),
    .DATA_W      (DW),
    .CAPTURE_LEN (LEN)
  ) dut (
    .i_clk          (clk),
    .i_rst          (rst),
    .i_arm          (arm),
    .i_trig         (trig),
    .i_adc_data     (adc_data),
    .i_adc_valid    (adc_valid),
    .i_fifo_full    (fifo_full),
    .i_fifo_empty   (fifo_empty),
    .o_wr_en        (wr_en),
    .o_wr_data      (wr_data),
    .o_capture_done (capture_done),
    .o_busy         (busy),
    .o_overflow     (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int n_wr_seen = 0;

  // Reference model: mode 0 idle, 1 armed, 2 capturing, 3 done
  int            m_mode;
  int            m_count;
  bit            m_ovf;
  logic [NF-1:0] m_wr_en;
  logic [DW-1:0] m_wr_data;
  bit            m_busy;
  bit            m_done;
  bit            trig_log[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_count = 0; m_ovf = 0;
    m_wr_en = '0; m_wr_data = '0; m_busy = 0; m_done = 0;
    // Trigger history before/at reset counts as low
    trig_log = '{1'b0, 1'b0, 1'b0, 1'b0};
  endtask

  // Advance the model by one clock edge using the inputs currently driven
  task automatic model_edge();
    bit re;
    int n;
    int tgt;
    if (rst) begin
      model_reset();
      return;
    end
    m_wr_en = '0;
    n  = trig_log.size();
    re = trig_log[n-3] && !trig_log[n-4];   // trigger level rose 3 samples ago
    trig_log.push_back(trig);
    case (m_mode)
      0: if (arm && fifo_empty == '1) begin m_mode = 1; m_ovf = 0; end
      1: if (re) begin m_mode = 2; m_count = 0; end
      2: if (adc_valid) begin
           tgt = m_count % NF;
           if (!fifo_full[tgt]) begin
             m_wr_en = NF'(1) << tgt;
`ifdef ADC_CAPTURE_TEST_PATTERN_EN
             m_wr_data = DW'(m_count);
`else
             m_wr_data = adc_data;
`endif
             m_count++;
             if (m_count == LEN) m_mode = 3;
           end else begin
             m_ovf = 1;
           end
         end
      3: if (fifo_empty == '1) m_mode = 0;
      default: m_mode = 0;
    endcase
    m_busy = (m_mode != 0);
    m_done = (m_mode == 3);
  endtask

  task automatic compare();
    chk("wr_en", 32'(wr_en), 32'(m_wr_en));
    if (m_wr_en != '0) chk("wr_data", 32'(wr_data), 32'(m_wr_data));
    chk("busy", 32'(busy), 32'(m_busy));
    chk("capture_done", 32'(capture_done), 32'(m_done));
    chk("overflow", 32'(overflow), 32'(m_ovf));
    if (wr_en != '0) n_wr_seen++;
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
    compare();
  endtask

  function automatic logic [DW-1:0] exp_sample(input int idx, input logic [DW-1:0] raw);
`ifdef ADC_CAPTURE_TEST_PATTERN_EN
    return DW'(idx) | (raw & '0);
`else
    return raw | DW'(idx & 0);
`endif
  endfunction

  typedef struct {
    logic          rst;
    logic          arm;
    logic          trig;
    logic [NF-1:0] empty;
    logic          e_busy;
    logic          e_done;
    logic [NF-1:0] e_wr_en;
    logic          e_ovf;
  } vec_t;

  function automatic vec_t mk(input logic r, input logic a, input logic t, input logic [NF-1:0] e,
                              input logic eb, input logic ed, input logic [NF-1:0] ew, input logic eo);
    vec_t v;
    v.rst = r; v.arm = a; v.trig = t; v.empty = e;
    v.e_busy = eb; v.e_done = ed; v.e_wr_en = ew; v.e_ovf = eo;
    return v;
  endfunction

  vec_t vecs[10];
  int   drops;
  int   writes0;
  bit   drop_now;
  bit   held_checked;
  logic [NF-1:0] ew;

  initial begin
    // rst arm trig empty   | busy done wr_en ovf
    vecs[0] = mk(1, 0, 0, 6'h3F, 0, 0, 6'h00, 0);  // reset
    vecs[1] = mk(0, 0, 0, 6'h3F, 0, 0, 6'h00, 0);  // idle
    vecs[2] = mk(0, 0, 1, 6'h3F, 0, 0, 6'h00, 0);  // trigger edge in IDLE
    vecs[3] = mk(0, 0, 1, 6'h3F, 0, 0, 6'h00, 0);
    vecs[4] = mk(0, 0, 1, 6'h3F, 0, 0, 6'h00, 0);
    vecs[5] = mk(0, 1, 0, 6'h3E, 0, 0, 6'h00, 0);  // arm blocked by non-empty FIFO0
    vecs[6] = mk(0, 0, 0, 6'h3E, 0, 0, 6'h00, 0);
    vecs[7] = mk(0, 1, 0, 6'h3F, 1, 0, 6'h00, 0);  // arm accepted
    vecs[8] = mk(0, 0, 0, 6'h3F, 1, 0, 6'h00, 0);  // stays ARMED
    vecs[9] = mk(0, 1, 0, 6'h3F, 1, 0, 6'h00, 0);  // arm in ARMED no effect

    rst = 1; arm = 0; trig = 0; adc_data = '0; adc_valid = 0;
    fifo_full = '0; fifo_empty = '1;
    model_reset();

    for (int i = 0; i < 10; i++) begin
      rst = vecs[i].rst; arm = vecs[i].arm; trig = vecs[i].trig;
      fifo_empty = vecs[i].empty; adc_valid = 0; fifo_full = '0; adc_data = DW'($urandom);
      step();
      chk($sformatf("vec%0d_busy", i), 32'(busy), 32'(vecs[i].e_busy));
      chk($sformatf("vec%0d_done", i), 32'(capture_done), 32'(vecs[i].e_done));
      chk($sformatf("vec%0d_wr_en", i), 32'(wr_en), 32'(vecs[i].e_wr_en));
      chk($sformatf("vec%0d_ovf", i), 32'(overflow), 32'(vecs[i].e_ovf));
      if (vecs[i].rst) chk("reset_wr_data", 32'(wr_data), 32'd0);
    end

    // Basic capture: valid held high, trigger rises; the trigger-cycle sample is skipped
    arm = 0; trig = 1; fifo_empty = '0; adc_valid = 1; adc_data = 16'h00FF;
    for (int k = 0; k < 4; k++) begin
      step();
      chk("pre_capture_no_write", 32'(wr_en), 32'd0);
    end
    for (int i = 0; i < LEN; i++) begin
      adc_data = DW'(16'h0100 + i);
      step();
      ew = NF'(1) << (i % NF);
      chk($sformatf("basic_wr_en%0d", i), 32'(wr_en), 32'(ew));
      chk($sformatf("basic_wr_data%0d", i), 32'(wr_data), 32'(exp_sample(i, DW'(16'h0100 + i))));
      chk($sformatf("basic_done%0d", i), 32'(capture_done), 32'(i == LEN - 1));
    end
    // DONE ignores arm/trig/valid while FIFOs hold data
    trig = 0; arm = 1;
    for (int k = 0; k < 4; k++) begin
      adc_valid = k[0];
      step();
      chk("done_hold", 32'(capture_done), 32'd1);
      chk("done_no_write", 32'(wr_en), 32'd0);
    end
    arm = 0; adc_valid = 0; fifo_empty = '1;
    step();
    chk("drain_done_low", 32'(capture_done), 32'd0);
    chk("drain_busy_low", 32'(busy), 32'd0);

    // Overflow: FIFO2 full for three valid samples
    arm = 1; step(); arm = 0;
    chk("ovf_armed", 32'(busy), 32'd1);
    trig = 1; fifo_empty = '0;
    for (int k = 0; k < 4; k++) step();
    drops = 0; writes0 = n_wr_seen; held_checked = 0;
    for (int k = 0; k < 40 && m_mode == 2; k++) begin
      adc_valid = 1; adc_data = DW'($urandom);
      drop_now = (m_count % NF == 2) && (drops < 3);
      fifo_full = drop_now ? 6'b000100 : 6'b000000;
      step();
      if (drop_now) begin
        drops++;
        chk("ovf_drop_no_write", 32'(wr_en), 32'd0);
        chk("ovf_sticky", 32'(overflow), 32'd1);
      end else if (drops == 3 && !held_checked) begin
        held_checked = 1;
        chk("ovf_ptr_held", 32'(wr_en), 32'h04);
      end
    end
    fifo_full = '0; adc_valid = 0;
    chk("ovf_total_writes", 32'(n_wr_seen - writes0), 32'(LEN));
    chk("ovf_done", 32'(capture_done), 32'd1);
    chk("ovf_still_set", 32'(overflow), 32'd1);
    trig = 0; fifo_empty = '1; step();
    arm = 1; step(); arm = 0;
    chk("ovf_cleared_by_arm", 32'(overflow), 32'd0);

    // Reset mid-capture after 5 writes
    step();
    trig = 1; fifo_empty = '0;
    for (int k = 0; k < 4; k++) step();
    adc_valid = 1;
    for (int k = 0; k < 5; k++) begin adc_data = DW'($urandom); step(); end
    rst = 1; step();
    chk("rst_mid_wr_en", 32'(wr_en), 32'd0);
    chk("rst_mid_busy", 32'(busy), 32'd0);
    chk("rst_mid_done", 32'(capture_done), 32'd0);
    rst = 0; adc_valid = 0; trig = 0; fifo_empty = '1; step();

    // Randomized traffic against the model
    for (int k = 0; k < 3000; k++) begin
      rst        = ($urandom_range(0, 699) == 0);
      arm        = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 19) == 0) trig = ~trig;
      adc_valid  = $urandom_range(0, 1) == 1;
      adc_data   = DW'($urandom);
      fifo_full  = ($urandom_range(0, 7) == 0) ? NF'($urandom) : '0;
      fifo_empty = ($urandom_range(0, 2) == 0) ? '1 : NF'($urandom);
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/adc_capture_writer.md
Name: adc_capture_writer

Overview:
- Upstream stage of the six-FIFO ADC capture buffer. It takes the ADC sample stream and arms on a software pulse.
- On trigger it writes a fixed-length capture round-robin across the NUM_FIFO sample FIFOs.
- It then raises capture_done, which drives the FIFO read controller's `full` input, and holds it until every FIFO has drained.
- It re-arms only after a new `arm` pulse.

Parameters:
- NUM_FIFO, 6, number of sample FIFOs written round-robin (index 0..NUM_FIFO-1).
- DATA_W, 16, ADC sample width in bits.
- CAPTURE_LEN, 6144, total samples per capture; must be at least NUM_FIFO and fit in 16 bits.

Ports:
- clk  in  1  system clock; all logic on its rising edge.
- rst  in  1  synchronous, active-high reset.
- arm  in  1  single-cycle arm request.
- trig  in  1  external trigger, asynchronous level.
- adc_data  in  DATA_W  ADC sample.
- adc_valid  in  1  adc_data is valid this cycle.
- fifo_full  in  NUM_FIFO  per-FIFO full flags.
- fifo_empty  in  NUM_FIFO  per-FIFO empty flags.
- wr_en  out  NUM_FIFO  one-hot FIFO write strobe.
- wr_data  out  DATA_W  data to be written.
- capture_done  out  1  capture complete, FIFOs hold data.
- busy  out  1  high in ARMED, CAPTURE and DONE.
- overflow  out  1  sticky: at least one sample was dropped because its target FIFO was full.

Behaviour:
- Reset:
  - State IDLE; wr_en=0, wr_data=0, capture_done=0, busy=0, overflow=0.
  - Write pointer=0, sample counter=0, trigger synchroniser flops=0.
  - Reset mid-capture abandons the capture immediately. FIFO contents are not touched by this block.
- Trigger path: trig passes through a 2-flop synchroniser, then a rising-edge detector, giving trig_re. Latency from trig to trig_re is 3 clk.
- All outputs are registered. A write accepted in cycle N appears as wr_en/wr_data in cycle N+1.
- IDLE:
  - arm=1 and &fifo_empty=1 -> ARMED; overflow clears.
  - arm while any FIFO is non-empty is ignored.
- ARMED:
  - trig_re=1 -> CAPTURE; pointer=0, counter=0.
  - A sample with adc_valid in the same cycle as trig_re is not captured; the first captured sample is the next valid one.
  - arm in ARMED has no effect.
- CAPTURE, on each adc_valid:
  - If fifo_full[ptr]=0: wr_en[ptr]=1 next cycle and wr_data=adc_data. ptr increments and wraps NUM_FIFO-1 -> 0. Counter increments.
  - If fifo_full[ptr]=1: sample dropped, overflow set to 1, and neither ptr nor counter advances. The next valid sample retries the same FIFO.
  - A write that brings the counter to CAPTURE_LEN moves the state to DONE. That last write is still issued.
  - No adc_valid means no write and no change.
- DONE:
  - capture_done=1 from the first DONE cycle.
  - &fifo_empty=1 -> IDLE, with capture_done deasserted in the IDLE cycle.
  - trig, arm and adc_valid are ignored.
  - Because capture_done stays high until everything is empty, the reader restarts after its pause periods.
- Exactly one wr_en bit is high in any cycle, or none.
- Counter is 16 bits; no wrap within a capture.

Optional Feature:
- Macro: ADC_CAPTURE_TEST_PATTERN_EN.
- Defined:
  - adc_data is ignored and wr_data carries a DATA_W-bit ramp.
  - The ramp resets to 0 on entry to CAPTURE and increments by 1 per accepted write, so the first sample is 0.
  - adc_valid still paces the writes.
  - Reader and Ethernet output can then be checked for gaps or reordering.
- Undefined: wr_data equals the registered adc_data. No ramp logic is synthesised.

Decomposition:
- Package adc_capture_pkg holds:
  - typedef enum logic [2:0] cap_state_t {IDLE, ARMED, CAPTURE, DONE}, one-hot encoded;
  - localparam NUM_FIFO_DEF=6 and ADDR_W=3, shared with the read controller.
- Sub-module trig_edge_detect: 2-flop synchroniser plus rising-edge pulse, clk/rst, 1-bit in and out.

Test Plan:
- Reset then idle: after rst, all outputs 0; arm with fifo_empty=6'h3F -> busy=1 next cycle, state ARMED.
- Basic capture:
  - Stimulus: CAPTURE_LEN=12, adc_valid held high, data 0x100..0x10B, trig rising.
  - Required: wr_en sequence 000001,000010,...,100000, twice; wr_data matches; capture_done=1 after the 12th write; stays 1 until fifo_empty=3F, then 0.
- Overflow:
  - Stimulus: fifo_full[2]=1 for 3 valid cycles mid-capture.
  - Required: 3 samples dropped, ptr held at 2, overflow=1 sticky; total writes still reach CAPTURE_LEN; the next arm clears overflow.
- Arm blocked: arm with fifo_empty=6'h3E -> stays IDLE, busy=0.
- Trigger/reset corners:
  - trig edge in IDLE -> no capture.
  - rst asserted mid-CAPTURE after 5 writes -> wr_en=0 next cycle, IDLE, capture_done=0.
- Test pattern: with ADC_CAPTURE_TEST_PATTERN_EN, adc_valid toggling 1/0 -> wr_data 0,1,2,... on consecutive writes, independent of adc_data.
